dm_access_stage: RTL and testbench

DM_ACCESS_STAGE -- requirements
Module: dm_access_stage

---
 rtl/dm_access_stage_pkg.sv | 28 ++
 rtl/dm_access_stage_if.sv | 24 ++
 rtl/dm_access_stage_dm_wb_reg.sv | 36 +++
 rtl/dm_access_stage.sv | 124 ++++++++++++
 tb/tb_dm_access_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dm_access_stage_pkg.sv
// Shared definitions for the data-memory access stage.
//   ASIZE / DSIZE / ISIZE : register-address, data and instruction-address widths used across
//                           the pipeline. Any other stage that needs them imports this package.
//   StIdle / StBusy       : encoding of the access FSM state.
package dm_access_stage_pkg;

  localparam int unsigned ASIZE = 5;
  localparam int unsigned DSIZE = 32;
  localparam int unsigned ISIZE = 32;

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  // Write-back source select: link address, then load data, then the ALU result.
  function automatic logic [DSIZE-1:0] wb_select(input logic             jal,
                                                 input logic             use_rdata,
                                                 input logic [ISIZE-1:0] npc,
                                                 input logic [DSIZE-1:0] rdata,
                                                 input logic [DSIZE-1:0] aluout);
    if (jal) begin
      return DSIZE'(npc);
    end else if (use_rdata) begin
      return rdata;
    end
    return aluout;
  endfunction

endpackage

// File: rtl/dm_access_stage_if.sv
// Data-memory request/response bus.
//   dm_req/dm_we/dm_addr/dm_wdata : request, driven by the master (access stage)
//   dm_rdata/dm_ready             : response, driven by the slave (data memory)
interface dm_access_stage_if;
  import dm_access_stage_pkg::*;

  logic             dm_req;
  logic             dm_we;
  logic [DSIZE-1:0] dm_addr;
  logic [DSIZE-1:0] dm_wdata;
  logic [DSIZE-1:0] dm_rdata;
  logic             dm_ready;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ready
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ready
  );

endinterface

// File: rtl/dm_access_stage_dm_wb_reg.sv
// DM/WB pipeline register with bubble insertion.
//   clk, rst (async, active-low)
//   bubble                         : load an empty slot instead of the incoming op
//   wen_in, waddr_in, wb_data_in   : op leaving the access stage
//   wen_out, waddr_out, wb_data_out: registered op toward write-back
module dm_wb_reg
  import dm_access_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble,
  input  logic             wen_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic [DSIZE-1:0] wb_data_in,
  output logic             wen_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic [DSIZE-1:0] wb_data_out
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_out     <= 1'b0;
      waddr_out   <= '0;
      wb_data_out <= '0;
    end else if (bubble) begin
      wen_out     <= 1'b0;
      waddr_out   <= '0;
      wb_data_out <= '0;
    end else begin
      wen_out     <= wen_in;
      waddr_out   <= waddr_in;
      wb_data_out <= wb_data_in;
    end
  end

endmodule

// File: rtl/dm_access_stage.sv
// Data-memory access stage: issues one memory request per load/store, freezes the earlier
// pipeline while the access is outstanding and feeds the DM/WB register.
//   clk, rst (async, active-low)
//   wen_in, mem_read_in, mem_write_in, mem_to_reg_in, jal_in, waddr_in, aluout_in,
//   read_data2_in, nPC_in      : EXE/DM pipeline register contents
//   dm (master modport)        : data-memory request/response bus
//   stall                      : freeze EXE/DM and all earlier stages
//   wen_out, waddr_out, wb_data_out : registered DM/WB outputs
//   dm_err                     : one-cycle timeout pulse (DM_TIMEOUT_EN only)
// Optional feature: define DM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES busy cycles
// without dm_ready; otherwise a busy access waits indefinitely.
module dm_access_stage
  import dm_access_stage_pkg::*;
`ifdef DM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wen_in,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic                mem_to_reg_in,
  input  logic                jal_in,
  input  logic [ASIZE-1:0]    waddr_in,
  input  logic [DSIZE-1:0]    aluout_in,
  input  logic [DSIZE-1:0]    read_data2_in,
  input  logic [ISIZE-1:0]    nPC_in,
  dm_access_stage_if.master   dm,
  output logic                stall,
  output logic                wen_out,
  output logic [ASIZE-1:0]    waddr_out,
  output logic [DSIZE-1:0]    wb_data_out
`ifdef DM_TIMEOUT_EN
  ,
  output logic                dm_err
`endif
);

  logic             state_q, state_d;
  logic [DSIZE-1:0] addr_q, wdata_q;
  logic             we_q;
  logic             mem_op, busy, abort;
  logic [DSIZE-1:0] wb_data;

  assign mem_op = mem_read_in | mem_write_in;
  assign busy   = (state_q == StBusy);

`ifdef DM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  // Abort on the last allowed busy cycle so stall is released in that same cycle.
  assign abort = busy & ~dm.dm_ready & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (busy & ~dm.dm_ready & ~abort) ? cnt_q + 1'b1 : '0;
      err_q <= abort;
    end
  end

  assign dm_err = err_q;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (mem_op) state_d = StBusy;
      StBusy: if (dm.dm_ready | abort) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!busy && mem_op) begin
        addr_q  <= aluout_in;
        wdata_q <= read_data2_in;
        we_q    <= mem_write_in;  // read+write together is a write
      end
    end
  end

  // dm_ready only matters while busy; rst gating keeps stall low throughout reset.
  assign stall = rst & (busy ? (~dm.dm_ready & ~abort) : mem_op);

  assign dm.dm_req   = busy;
  assign dm.dm_we    = busy & we_q;
  assign dm.dm_addr  = busy ? addr_q : '0;
  assign dm.dm_wdata = busy ? wdata_q : '0;

  // A write never returns memory data, even if mem_to_reg is also set.
  assign wb_data = wb_select(jal_in, mem_to_reg_in & ~mem_write_in, nPC_in, dm.dm_rdata,
                             aluout_in);

  dm_wb_reg u_dm_wb_reg (
    .clk         (clk),
    .rst         (rst),
    .bubble      (stall | abort),
    .wen_in      (wen_in),
    .waddr_in    (waddr_in),
    .wb_data_in  (wb_data),
    .wen_out     (wen_out),
    .waddr_out   (waddr_out),
    .wb_data_out (wb_data_out)
  );

endmodule

// File: tb/tb_dm_access_stage.sv
module tb_dm_access_stage;
  import dm_access_stage_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             wen_in, mem_read_in, mem_write_in, mem_to_reg_in, jal_in;
  logic [ASIZE-1:0] waddr_in;
  logic [DSIZE-1:0] aluout_in, read_data2_in;
  logic [ISIZE-1:0] nPC_in;
  logic             stall, wen_out;
  logic [ASIZE-1:0] waddr_out;
  logic [DSIZE-1:0] wb_data_out;
`ifdef DM_TIMEOUT_EN
  logic             dm_err;
`endif

  dm_access_stage_if dm_if ();

  dm_access_stage dut (
    .clk           (clk),
    .rst           (rst),
    .wen_in        (wen_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .mem_to_reg_in (mem_to_reg_in),
    .jal_in        (jal_in),
    .waddr_in      (waddr_in),
    .aluout_in     (aluout_in),
    .read_data2_in (read_data2_in),
    .nPC_in        (nPC_in),
    .dm            (dm_if),
    .stall         (stall),
    .wen_out       (wen_out),
    .waddr_out     (waddr_out),
    .wb_data_out   (wb_data_out)
`ifdef DM_TIMEOUT_EN
    ,
    .dm_err        (dm_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, m2r, jal, wen;
    logic [4:0]  waddr;
    logic [31:0] alu, data2, npc, rdata;
    int          delay;      // not-ready busy cycles before dm_ready
    logic        exp_we;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wb;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int nvec = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    mem_read_in   = v.rd;
    mem_write_in  = v.wr;
    mem_to_reg_in = v.m2r;
    jal_in        = v.jal;
    wen_in        = v.wen;
    waddr_in      = v.waddr;
    aluout_in     = v.alu;
    read_data2_in = v.data2;
    nPC_in        = v.npc;
  endtask

  task automatic drive_nop();
    mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0; jal_in = 0; wen_in = 0;
    waddr_in = '0; aluout_in = '0; read_data2_in = '0; nPC_in = '0;
  endtask

  initial begin
    //          rd wr m2r jal wen waddr alu           data2         npc           rdata
    //          delay we wen waddr wb
    vecs[0] = '{0, 0, 0, 0, 1, 5'd3,  32'h1111_1111, 32'h0, 32'h0, 32'h0,
                0, 0, 1, 5'd3,  32'h1111_1111};
    vecs[1] = '{0, 0, 0, 1, 1, 5'd31, 32'h0000_0005, 32'h0, 32'h100, 32'h0,
                0, 0, 1, 5'd31, 32'h0000_0100};
    vecs[2] = '{1, 0, 1, 0, 1, 5'd5,  32'h0000_0040, 32'h0, 32'h0, 32'hDEAD_BEEF,
                1, 0, 1, 5'd5,  32'hDEAD_BEEF};
    vecs[3] = '{0, 1, 0, 0, 0, 5'd0,  32'h0000_0010, 32'h1234, 32'h0, 32'h0,
                0, 1, 0, 5'd0,  32'h0000_0010};
    vecs[4] = '{1, 1, 1, 0, 0, 5'd9,  32'h0000_0020, 32'h55AA, 32'h0, 32'hFFFF_FFFF,
                2, 1, 0, 5'd9,  32'h0000_0020};
    vecs[5] = '{1, 0, 1, 0, 1, 5'd12, 32'h0000_0044, 32'h0, 32'h0, 32'h0BAD_F00D,
                0, 0, 1, 5'd12, 32'h0BAD_F00D};
    vecs[6] = '{0, 0, 1, 1, 1, 5'd1,  32'h0000_0077, 32'h0, 32'h0000_0200, 32'h0,
                0, 0, 1, 5'd1,  32'h0000_0200};
    vecs[7] = '{0, 0, 0, 0, 0, 5'd7,  32'hA5A5_0000, 32'h0, 32'h0, 32'h0,
                0, 0, 0, 5'd7,  32'hA5A5_0000};
    vecs[8] = '{1, 0, 0, 0, 1, 5'd4,  32'h0000_0080, 32'h0, 32'h0, 32'h7777_7777,
                1, 0, 1, 5'd4,  32'h0000_0080};

    // Reset with a memory op already presented: everything must stay low.
    rst = 1'b0;
    drive_nop();
    mem_read_in = 1; wen_in = 1; waddr_in = 5'd2; aluout_in = 32'h44;
    dm_if.dm_ready = 0;
    dm_if.dm_rdata = 32'h0;
    #12;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_req", {31'b0, dm_if.dm_req}, 32'd0);
    check("rst_wen", {31'b0, wen_out}, 32'd0);
    check("rst_waddr", {27'b0, waddr_out}, 32'd0);
    check("rst_wb", wb_data_out, 32'd0);
    drive_nop();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      if (vecs[i].rd || vecs[i].wr) begin
        @(negedge clk);
        check($sformatf("v%0d_idle_stall", i), {31'b0, stall}, 32'd1);
        check($sformatf("v%0d_idle_req", i), {31'b0, dm_if.dm_req}, 32'd0);
        @(posedge clk); #1;
        for (int d = 0; d <= vecs[i].delay; d++) begin
          dm_if.dm_ready = (d == vecs[i].delay);
          dm_if.dm_rdata = (d == vecs[i].delay) ? vecs[i].rdata : 32'h0BAD_0BAD;
          @(negedge clk);
          check($sformatf("v%0d_req", i), {31'b0, dm_if.dm_req}, 32'd1);
          check($sformatf("v%0d_addr", i), dm_if.dm_addr, vecs[i].alu);
          check($sformatf("v%0d_we", i), {31'b0, dm_if.dm_we}, {31'b0, vecs[i].exp_we});
          if (vecs[i].exp_we)
            check($sformatf("v%0d_wdata", i), dm_if.dm_wdata, vecs[i].data2);
          check($sformatf("v%0d_busy_stall", i), {31'b0, stall},
                {31'b0, d != vecs[i].delay});
          check($sformatf("v%0d_bubble_wen", i), {31'b0, wen_out}, 32'd0);
          check($sformatf("v%0d_bubble_wb", i), wb_data_out, 32'd0);
          @(posedge clk); #1;
        end
        dm_if.dm_ready = 0;
        check($sformatf("v%0d_done_req", i), {31'b0, dm_if.dm_req}, 32'd0);
      end else begin
        @(negedge clk);
        check($sformatf("v%0d_stall", i), {31'b0, stall}, 32'd0);
        check($sformatf("v%0d_req", i), {31'b0, dm_if.dm_req}, 32'd0);
        @(posedge clk); #1;
      end
      check($sformatf("v%0d_wen", i), {31'b0, wen_out}, {31'b0, vecs[i].exp_wen});
      check($sformatf("v%0d_waddr", i), {27'b0, waddr_out}, {27'b0, vecs[i].exp_waddr});
      check($sformatf("v%0d_wb", i), wb_data_out, vecs[i].exp_wb);
    end

    // Reset asserted mid-access: request and stall drop without a clock edge, no commit.
    drive(vecs[2]);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_busy_req", {31'b0, dm_if.dm_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, dm_if.dm_req}, 32'd0);
    check("mid_rst_stall", {31'b0, stall}, 32'd0);
    dm_if.dm_ready = 1;
    dm_if.dm_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dm_if.dm_ready = 0;
    drive_nop();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_wen", {31'b0, wen_out}, 32'd0);
    check("mid_rst_wb", wb_data_out, 32'd0);
    check("mid_rst_idle", {31'b0, dm_if.dm_req}, 32'd0);

`ifdef DM_TIMEOUT_EN
    begin
      int busy_cycles;
      bit released;
      busy_cycles = 0;
      released = 0;
      drive(vecs[5]);
      dm_if.dm_ready = 0;
      @(posedge clk); #1;
      for (int c = 0; c < 40 && !released; c++) begin
        @(negedge clk);
        if (dm_if.dm_req) busy_cycles++;
        if (dm_if.dm_req && !stall) released = 1;
        check("to_no_err_yet", {31'b0, dm_err}, 32'd0);
        @(posedge clk); #1;
      end
      check("to_released", {31'b0, released}, 32'd1);
      check("to_busy_cycles", busy_cycles, 32'd16);
      drive_nop();
      check("to_err_pulse", {31'b0, dm_err}, 32'd1);
      check("to_wen", {31'b0, wen_out}, 32'd0);
      check("to_req", {31'b0, dm_if.dm_req}, 32'd0);
      @(posedge clk); #1;
      check("to_err_once", {31'b0, dm_err}, 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
